rom_bus_ctrl: RTL and testbench

- Bus-side controller that sits directly upstream of the BASIC ROM.
- Decodes CPU reads in the ROM window and drives the ROM's 12-bit address.
- Absorbs the ROM's registered-output latency by holding the CPU with rdy.
- Captures the ROM data byte and presents it with a one-cycle valid pulse; also flags illegal writes and counts ROM reads.

---
 rtl/rom_bus_ctrl.sv | 155 +++++++++++++++
 tb/tb_rom_bus_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_ctrl.sv
// Bus-side controller for the BASIC ROM: decodes reads and holds the CPU through the ROM latency.
// It also captures the ROM byte, flags writes into the window and counts completed reads.
// Optional last-address shadow buffer enabled by defining ROM_SHADOW_EN.

module rom_bus_ctrl #(
  parameter logic [15:0] BASE_ADDR   = 16'hE000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_strobe,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_dout,
  output logic        data_valid,
  output logic        sel,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_dout,
  output logic        wr_err,
  output logic [15:0] rd_count
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  dout_q, dout_d;
  logic        dv_q, dv_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic        wr_err_q, wr_err_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] rd_count_inc;
  logic        rd_req;
  logic        wr_req;
  logic        shadow_hit;

`ifdef ROM_SHADOW_EN
  logic [11:0] tag_q, tag_d;
  logic        tag_valid_q, tag_valid_d;

  assign shadow_hit = tag_valid_q && (tag_q == cpu_addr[11:0]);
`else
  assign shadow_hit = 1'b0;
`endif

  assign sel          = (cpu_addr[15:12] == BASE_ADDR[15:12]);
  assign rd_req       = cpu_strobe & sel & ~cpu_we;
  assign wr_req       = cpu_strobe & sel & cpu_we;
  assign rd_count_inc = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdy_d      = rdy_q;
    dout_d     = dout_q;
    dv_d       = 1'b0;
    rom_addr_d = rom_addr_q;
    wr_err_d   = wr_err_q;
    rd_count_d = rd_count_q;
`ifdef ROM_SHADOW_EN
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          if (shadow_hit) begin
            // cpu_dout already holds the byte for this address
            dv_d       = 1'b1;
            rd_count_d = rd_count_inc;
          end else begin
            rom_addr_d = cpu_addr[11:0];
            cnt_d      = WAIT_LOAD;
            rdy_d      = 1'b0;
            state_d    = ST_WAIT;
          end
        end else if (wr_req) begin
          wr_err_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_CAPTURE: begin
        dout_d     = rom_dout;
        dv_d       = 1'b1;
        rdy_d      = 1'b1;
        rd_count_d = rd_count_inc;
        state_d    = ST_IDLE;
`ifdef ROM_SHADOW_EN
        tag_d       = rom_addr_q;
        tag_valid_d = 1'b1;
`endif
      end

      default: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      rdy_q       <= 1'b1;
      dout_q      <= 8'h00;
      dv_q        <= 1'b0;
      rom_addr_q  <= 12'h000;
      wr_err_q    <= 1'b0;
      rd_count_q  <= 16'h0000;
`ifdef ROM_SHADOW_EN
      tag_q       <= 12'h000;
      tag_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
      dout_q      <= dout_d;
      dv_q        <= dv_d;
      rom_addr_q  <= rom_addr_d;
      wr_err_q    <= wr_err_d;
      rd_count_q  <= rd_count_d;
`ifdef ROM_SHADOW_EN
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
`endif
    end
  end

  assign cpu_rdy    = rdy_q;
  assign cpu_dout   = dout_q;
  assign data_valid = dv_q;
  assign rom_addr   = rom_addr_q;
  assign wr_err     = wr_err_q;
  assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Randomised self-checking bench for rom_bus_ctrl against a transaction-level reference model.
// Honours ROM_SHADOW_EN when the design is built with it.

module tb_rom_bus_ctrl;

   localparam logic [15:0] BASE_ADDR   = 16'hE000;
   localparam int          WAIT_CYCLES = 1;

   logic        clk;
   logic        reset_n;
   logic        cpuStrobe;
   logic        cpuWe;
   logic [15:0] cpuAddr;
   logic        cpuRdy;
   logic [7:0]  cpuDout;
   logic        dataValid;
   logic        sel;
   logic [11:0] romAddr;
   logic [7:0]  romDout;
   logic        wrErr;
   logic [15:0] rdCount;

   int testsRun;
   int failCount;

   // Reference model state, tracked per transaction
   logic [7:0]  romMem [4096];
   int          expCount;
   logic        expWrErr;
   logic [7:0]  expDout;
   logic [11:0] expRomAddr;
   logic        tagValid;
   logic [11:0] tagAddr;

   rom_bus_ctrl #(
      .BASE_ADDR   (BASE_ADDR),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_strobe (cpuStrobe),
      .cpu_we     (cpuWe),
      .cpu_addr   (cpuAddr),
      .cpu_rdy    (cpuRdy),
      .cpu_dout   (cpuDout),
      .data_valid (dataValid),
      .sel        (sel),
      .rom_addr   (romAddr),
      .rom_dout   (romDout),
      .wr_err     (wrErr),
      .rd_count   (rdCount)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The ROM itself: registered output, one clock behind its address
   always @(posedge clk) begin
      romDout <= romMem[romAddr];
   end

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic resetModel();
      expCount   = 0;
      expWrErr   = 1'b0;
      expDout    = 8'h00;
      expRomAddr = 12'h000;
      tagValid   = 1'b0;
      tagAddr    = 12'h000;
   endtask

   task automatic checkIdleState(input string tag);
      checkOutput({tag, "_rdy"},   32'(cpuRdy),     32'd1);
      checkOutput({tag, "_dv"},    32'(dataValid),  32'd0);
      checkOutput({tag, "_dout"},  32'(cpuDout),    32'(expDout));
      checkOutput({tag, "_wrerr"}, 32'(wrErr),      32'(expWrErr));
      checkOutput({tag, "_cnt"},   32'(rdCount),    32'(expCount));
      checkOutput({tag, "_raddr"}, 32'(romAddr),    32'(expRomAddr));
   endtask

   // Issue one bus request while the controller is idle and follow it to completion.
   // Entered and left at 1 time unit after a rising edge.
   task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic backToBack);
      logic hit;
      logic shadowHit;
      cpuStrobe = 1'b1;
      cpuAddr   = addr;
      cpuWe     = we;
      #1;
      hit = (addr[15:12] == BASE_ADDR[15:12]);
      checkOutput("sel", 32'(sel), 32'(hit));
      shadowHit = 1'b0;
`ifdef ROM_SHADOW_EN
      shadowHit = tagValid && (tagAddr == addr[11:0]);
`endif
      @(posedge clk);
      #1;
      if (hit && !we && shadowHit) begin
         expCount = (expCount == 65535) ? 65535 : expCount + 1;
         checkOutput("shadow_rdy",  32'(cpuRdy),    32'd1);
         checkOutput("shadow_dv",   32'(dataValid), 32'd1);
         checkOutput("shadow_dout", 32'(cpuDout),   32'(expDout));
         checkOutput("shadow_cnt",  32'(rdCount),   32'(expCount));
         checkOutput("shadow_raddr", 32'(romAddr),  32'(expRomAddr));
      end else if (hit && !we) begin
         expRomAddr = addr[11:0];
         checkOutput("rd_raddr", 32'(romAddr), 32'(expRomAddr));
         for (int k = 0; k < WAIT_CYCLES + 1; k++) begin
            checkOutput("rd_stall_rdy", 32'(cpuRdy),    32'd0);
            checkOutput("rd_stall_dv",  32'(dataValid), 32'd0);
            @(posedge clk);
            #1;
         end
         expDout  = romMem[addr[11:0]];
         expCount = (expCount == 65535) ? 65535 : expCount + 1;
         tagValid = 1'b1;
         tagAddr  = addr[11:0];
         checkOutput("rd_dv",   32'(dataValid), 32'd1);
         checkOutput("rd_rdy",  32'(cpuRdy),    32'd1);
         checkOutput("rd_dout", 32'(cpuDout),   32'(expDout));
         checkOutput("rd_cnt",  32'(rdCount),   32'(expCount));
      end else begin
         if (hit && we) begin
            expWrErr = 1'b1;
         end
         checkIdleState(we ? "wr" : "miss");
      end
      if (!backToBack) begin
         cpuStrobe = 1'b0;
         cpuWe     = 1'($urandom);
         cpuAddr   = 16'($urandom);
         @(posedge clk);
         #1;
         checkIdleState("gap");
      end
   endtask

   initial begin
      testsRun  = 0;
      failCount = 0;
      cpuStrobe = 1'b0;
      cpuWe     = 1'b0;
      cpuAddr   = 16'h0000;
      reset_n   = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         romMem[i] = 8'($urandom);
      end
      romMem[12'h123] = 8'hA5;
      resetModel();

      // Asynchronous reset, checked before any clock edge can mask it
      #2;
      reset_n = 1'b0;
      #1;
      checkIdleState("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single read with a known ROM byte
      applyStimulus(16'hE123, 1'b0, 1'b0);
      checkOutput("first_dout", 32'(cpuDout), 32'h0000_00A5);

      // Write into the window, then a read outside it
      applyStimulus(16'hE000, 1'b1, 1'b0);
      checkOutput("wrerr_set", 32'(wrErr), 32'd1);
      applyStimulus(16'hD010, 1'b0, 1'b0);

      // Back-to-back reads, second strobe in the data_valid cycle
      applyStimulus(16'hE000, 1'b0, 1'b1);
      applyStimulus(16'hE001, 1'b0, 1'b0);

      // Same address twice: the shadow path when enabled, two full reads otherwise
      applyStimulus(16'hE200, 1'b0, 1'b0);
      applyStimulus(16'hE200, 1'b0, 1'b0);

      // Reset in the middle of a read aborts it
      cpuStrobe = 1'b1;
      cpuWe     = 1'b0;
      cpuAddr   = 16'hE456;
      @(posedge clk);
      #1;
      checkOutput("abort_stalled", 32'(cpuRdy), 32'd0);
      reset_n = 1'b0;
      #1;
      resetModel();
      checkIdleState("abort");
      cpuStrobe = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkIdleState("after_abort");
      applyStimulus(16'hE456, 1'b0, 1'b0);

      // Random traffic, biased toward the window and toward repeated addresses
      for (int n = 0; n < 80; n++) begin
         logic [15:0] a;
         if ($urandom_range(0, 4) == 0 && tagValid) begin
            a = {BASE_ADDR[15:12], tagAddr};
         end else if ($urandom_range(0, 3) != 0) begin
            a = {BASE_ADDR[15:12], 12'($urandom)};
         end else begin
            a = 16'($urandom);
         end
         applyStimulus(a, ($urandom_range(0, 4) == 0), 1'($urandom));
      end

      // Preload the counter near saturation and read past the top
      force dut.rd_count_q = 16'hFFFD;
      @(posedge clk);
      #1;
      release dut.rd_count_q;
      expCount = 65533;
      checkOutput("sat_preload", 32'(rdCount), 32'h0000_FFFD);
      for (int n = 0; n < 4; n++) begin
         applyStimulus({BASE_ADDR[15:12], 12'($urandom)}, 1'b0, 1'($urandom));
      end
      checkOutput("sat_hold", 32'(rdCount), 32'h0000_FFFF);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
